// File: rtl/dram_schedule_checker_pkg.sv
// Shared widths, opcodes, error-bit positions and checker state encoding
// for the DRAM schedule checker.
package dram_schedule_checker_pkg;
  localparam int ROW_WIDTH        = 16;
  localparam int CYCLE_WIDTH      = 16;
  localparam int REQUEST_ID_WIDTH = 8;

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_PRE = 3'd2;
  localparam logic [2:0] CMD_RD  = 3'd3;

  localparam int ERR_ACT_OPEN  = 0;
  localparam int ERR_RD_CLOSED = 1;
  localparam int ERR_TRCD      = 2;
  localparam int ERR_TRP       = 3;
  localparam int ERR_TRAS      = 4;
  localparam int ERR_REQ_ID    = 5;
  localparam int ERR_OPCODE    = 6;
  localparam int ERR_COUNT     = 7;

  localparam int T_RCD_DEF = 14;
  localparam int T_RP_DEF  = 14;
  localparam int T_RAS_DEF = 32;
  localparam int TAIL_DEF  = 10;

  typedef enum logic [1:0] {
    CHK_IDLE  = 2'd0,
    CHK_SCAN  = 2'd1,
    CHK_DRAIN = 2'd2,
    CHK_FINAL = 2'd3
  } chk_state_t;
endpackage

// File: rtl/dram_chk_bank_tracker.sv
// Per-bank open/ACT/PRE history; flags timing and open/closed violations
// for the bank addressed by the entry currently being checked.
module dram_chk_bank_tracker
  import dram_schedule_checker_pkg::*;
#(
  parameter int BANK_IDX_W = 4,
  parameter int CYCLE_W    = CYCLE_WIDTH,
  parameter int T_RCD      = T_RCD_DEF,
  parameter int T_RP       = T_RP_DEF,
  parameter int T_RAS      = T_RAS_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  vld,
  input  logic [2:0]            op,
  input  logic [BANK_IDX_W-1:0] bank,
  input  logic [CYCLE_W-1:0]    t,
  output logic [4:0]            viol
);
  localparam int NUM_BANKS = 1 << BANK_IDX_W;
  localparam logic [CYCLE_W-1:0] T_RCD_C = CYCLE_W'(T_RCD);
  localparam logic [CYCLE_W-1:0] T_RP_C  = CYCLE_W'(T_RP);
  localparam logic [CYCLE_W-1:0] T_RAS_C = CYCLE_W'(T_RAS);

  logic [NUM_BANKS-1:0] open_q;
  logic [NUM_BANKS-1:0] pre_vld_q;
  logic [CYCLE_W-1:0]   last_act_q [NUM_BANKS];
  logic [CYCLE_W-1:0]   last_pre_q [NUM_BANKS];
  logic [CYCLE_W-1:0]   d_act;
  logic [CYCLE_W-1:0]   d_pre;

  always_comb begin
    viol  = '0;
    d_act = t - last_act_q[bank];
    d_pre = t - last_pre_q[bank];
    case (op)
      CMD_ACT: begin
        viol[ERR_ACT_OPEN] = open_q[bank];
        viol[ERR_TRP]      = pre_vld_q[bank] && (d_pre < T_RP_C);
      end
      CMD_PRE: viol[ERR_TRAS] = open_q[bank] && (d_act < T_RAS_C);
      CMD_RD: begin
        viol[ERR_RD_CLOSED] = !open_q[bank];
        viol[ERR_TRCD]      = open_q[bank] && (d_act < T_RCD_C);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || clear) begin
      open_q    <= '0;
      pre_vld_q <= '0;
      for (int i = 0; i < NUM_BANKS; i++) begin
        last_act_q[i] <= '0;
        last_pre_q[i] <= '0;
      end
    end else if (vld) begin
      if (op == CMD_ACT) begin
        open_q[bank]     <= 1'b1;
        last_act_q[bank] <= t;
      end else if (op == CMD_PRE) begin
        open_q[bank]     <= 1'b0;
        pre_vld_q[bank]  <= 1'b1;
        last_pre_q[bank] <= t;
      end
    end
  end
endmodule

// File: rtl/dram_schedule_checker.sv
// Walks a finished schedule table through its read port and checks bank
// timing, request-ID uniqueness and total read count.
//   state     | meaning
//   CHK_IDLE  | waiting for start; results held
//   CHK_SCAN  | issuing table reads 0..max_cycle+TAIL
//   CHK_DRAIN | no new reads; in-flight entries still checked
//   CHK_FINAL | read-count check, done/pass update
module dram_schedule_checker
  import dram_schedule_checker_pkg::*;
#(
  parameter int BG_W       = 2,
  parameter int BANK_W     = 2,
  parameter int ROW_W      = ROW_WIDTH,
  parameter int CYCLE_W    = CYCLE_WIDTH,
  parameter int REQ_ID_W   = REQUEST_ID_WIDTH,
  parameter int MAX_REQS   = 64,
  parameter int RD_LATENCY = 1,
  parameter int TAIL       = TAIL_DEF,
  parameter int T_RCD      = T_RCD_DEF,
  parameter int T_RP       = T_RP_DEF,
  parameter int T_RAS      = T_RAS_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [CYCLE_W-1:0]     max_cycle,
  input  logic [REQ_ID_W-1:0]    expected_reads,
  output logic                   rd_en,
  output logic [CYCLE_W-1:0]     rd_cycle,
  input  logic [2:0]             cmd_type,
  input  logic [BG_W-1:0]        cmd_bg,
  input  logic [BANK_W-1:0]      cmd_bank,
  input  logic [ROW_W-1:0]       cmd_row,
  input  logic [REQ_ID_W-1:0]    cmd_req_id,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [7:0]             err_flags,
  output logic [CYCLE_W-1:0]     err_cycle,
  output logic [BG_W+BANK_W-1:0] err_bank,
  output logic [REQ_ID_W:0]      read_count
);
  localparam int BANK_IDX_W = BG_W + BANK_W;
  localparam int ID_IDX_W   = $clog2(MAX_REQS);
  localparam logic [2:0] DRAIN_INIT = 3'(RD_LATENCY - 1);

  chk_state_t            state_q, state_d;
  logic [CYCLE_W:0]      idx_q;
  logic [CYCLE_W:0]      last_idx;
  logic [2:0]            drain_q;
  logic [CYCLE_W-1:0]    max_q;
  logic [REQ_ID_W-1:0]   exp_q;
  logic [MAX_REQS-1:0]   seen_q;
  logic [RD_LATENCY-1:0] vld_pipe;
  logic [CYCLE_W-1:0]    idx_pipe [RD_LATENCY];
  logic                  chk_vld, is_rd, op_err, id_err, count_ok, start_ok;
  logic [CYCLE_W-1:0]    chk_t;
  logic [BANK_IDX_W-1:0] chk_bank;
  logic [4:0]            bank_viol;
  logic [6:0]            new_err;
  logic                  unused_row;

  assign unused_row = ^cmd_row;
  assign start_ok   = (state_q == CHK_IDLE) && start;
  assign last_idx   = {1'b0, max_q} + (CYCLE_W+1)'(TAIL);
  assign rd_en      = (state_q == CHK_SCAN);
  assign busy       = (state_q != CHK_IDLE);
  assign rd_cycle   = idx_q[CYCLE_W-1:0];
  assign chk_vld    = vld_pipe[RD_LATENCY-1];
  assign chk_t      = idx_pipe[RD_LATENCY-1];
  assign chk_bank   = {cmd_bg, cmd_bank};
  assign is_rd      = (cmd_type == CMD_RD);
  assign op_err     = (cmd_type != CMD_NOP) && (cmd_type != CMD_ACT) &&
                      (cmd_type != CMD_PRE) && !is_rd;
  assign id_err     = is_rd && ((32'(cmd_req_id) >= 32'(MAX_REQS)) ||
                                seen_q[cmd_req_id[ID_IDX_W-1:0]]);
  assign new_err    = chk_vld ? {op_err, id_err, bank_viol} : 7'd0;
  assign count_ok   = (read_count == {1'b0, exp_q});

  dram_chk_bank_tracker #(
    .BANK_IDX_W(BANK_IDX_W), .CYCLE_W(CYCLE_W),
    .T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS)
  ) u_bank_tracker (
    .clk(clk), .rst_n(rst_n), .clear(start_ok), .vld(chk_vld),
    .op(cmd_type), .bank(chk_bank), .t(chk_t), .viol(bank_viol)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      CHK_IDLE:  if (start) state_d = CHK_SCAN;
      CHK_SCAN:  if (idx_q == last_idx) state_d = CHK_DRAIN;
      CHK_DRAIN: if (drain_q == 3'd0) state_d = CHK_FINAL;
      CHK_FINAL: state_d = CHK_IDLE;
      default:   state_d = CHK_IDLE;
    endcase
  end

  // Issued index travels alongside the table's read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int i = 0; i < RD_LATENCY; i++) idx_pipe[i] <= '0;
    end else begin
      vld_pipe[0] <= rd_en;
      idx_pipe[0] <= rd_cycle;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        idx_pipe[i] <= idx_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CHK_IDLE;
      idx_q      <= '0;
      drain_q    <= '0;
      max_q      <= '0;
      exp_q      <= '0;
      seen_q     <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_flags  <= '0;
      err_cycle  <= '0;
      err_bank   <= '0;
      read_count <= '0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      case (state_q)
        CHK_IDLE: if (start) begin
          max_q      <= max_cycle;
          exp_q      <= expected_reads;
          idx_q      <= '0;
          seen_q     <= '0;
          pass       <= 1'b0;
          err_flags  <= '0;
          err_cycle  <= '0;
          err_bank   <= '0;
          read_count <= '0;
        end
        CHK_SCAN: begin
          if (idx_q == last_idx) begin
            idx_q   <= '0;
            drain_q <= DRAIN_INIT;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        CHK_DRAIN: if (drain_q != 3'd0) drain_q <= drain_q - 3'd1;
        CHK_FINAL: begin
          done <= 1'b1;
          pass <= (err_flags == 8'd0) && count_ok;
          if (!count_ok) begin
            err_flags[ERR_COUNT] <= 1'b1;
            if (err_flags == 8'd0) err_cycle <= last_idx[CYCLE_W-1:0];
          end
        end
        default: ;
      endcase
      if (chk_vld) begin
        if (is_rd) begin
          if (~&read_count) read_count <= read_count + 1'b1;
          if (!id_err) seen_q[cmd_req_id[ID_IDX_W-1:0]] <= 1'b1;
        end
        if (new_err != 7'd0) begin
          err_flags <= err_flags | {1'b0, new_err};
          if (err_flags == 8'd0) begin
            err_cycle <= chk_t;
            err_bank  <= chk_bank;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_dram_schedule_checker.sv
// Directed bench: two checkers (read latency 1 and 3) walk the same table
// model; expected results are queued at start and compared at done.
module tb_dram_schedule_checker;
  import dram_schedule_checker_pkg::*;
  localparam int CW = CYCLE_WIDTH;
  localparam int IW = REQUEST_ID_WIDTH;
  localparam int RW = ROW_WIDTH;

  typedef struct packed {
    logic [2:0] op; logic [3:0] bank; logic [RW-1:0] row; logic [IW-1:0] id;
  } ent_t;
  typedef struct packed {
    logic [7:0] flags; logic [CW-1:0] cyc; logic [3:0] bank; logic [IW:0] rc; logic pass;
  } res_t;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [CW-1:0] max_cycle = '0;
  logic [IW-1:0] expected_reads = '0;
  logic rd_en1, busy1, done1, pass1, rd_en3, busy3, done3, pass3;
  logic [CW-1:0] rd_cycle1, err_cycle1, rd_cycle3, err_cycle3;
  logic [7:0] err_flags1, err_flags3;
  logic [3:0] err_bank1, err_bank3;
  logic [IW:0] read_count1, read_count3;
  ent_t d1;
  ent_t p3 [3];
  ent_t tbl [128];
  res_t q1[$], q3[$];
  int n_tests = 0, n_fail = 0, done_cnt1 = 0, done_cnt3 = 0;

  always #5 clk = ~clk;

  function automatic ent_t look(input logic [CW-1:0] c);
    return (c < CW'(128)) ? tbl[c[6:0]] : '0;
  endfunction

  always @(posedge clk) d1 <= look(rd_cycle1);
  always @(posedge clk) begin
    p3[0] <= look(rd_cycle3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  dram_schedule_checker #(.RD_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .max_cycle(max_cycle),
    .expected_reads(expected_reads), .rd_en(rd_en1), .rd_cycle(rd_cycle1),
    .cmd_type(d1.op), .cmd_bg(d1.bank[3:2]), .cmd_bank(d1.bank[1:0]),
    .cmd_row(d1.row), .cmd_req_id(d1.id), .busy(busy1), .done(done1),
    .pass(pass1), .err_flags(err_flags1), .err_cycle(err_cycle1),
    .err_bank(err_bank1), .read_count(read_count1));

  dram_schedule_checker #(.RD_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .max_cycle(max_cycle),
    .expected_reads(expected_reads), .rd_en(rd_en3), .rd_cycle(rd_cycle3),
    .cmd_type(p3[2].op), .cmd_bg(p3[2].bank[3:2]), .cmd_bank(p3[2].bank[1:0]),
    .cmd_row(p3[2].row), .cmd_req_id(p3[2].id), .busy(busy3), .done(done3),
    .pass(pass3), .err_flags(err_flags3), .err_cycle(err_cycle3),
    .err_bank(err_bank3), .read_count(read_count3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_res(input string who, input res_t e, input res_t g);
    chk({who, " err_flags"}, 32'(g.flags), 32'(e.flags));
    chk({who, " err_cycle"}, 32'(g.cyc), 32'(e.cyc));
    chk({who, " err_bank"}, 32'(g.bank), 32'(e.bank));
    chk({who, " read_count"}, 32'(g.rc), 32'(e.rc));
    chk({who, " pass"}, 32'(g.pass), 32'(e.pass));
  endtask

  // Scoreboard pop on each done pulse
  always @(posedge clk) begin
    #1;
    if (done1) begin
      done_cnt1++;
      chk("l1 sb nonempty", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0)
        cmp_res("l1", q1.pop_front(), {err_flags1, err_cycle1, err_bank1, read_count1, pass1});
    end
    if (done3) begin
      done_cnt3++;
      chk("l3 sb nonempty", 32'(q3.size() != 0), 32'd1);
      if (q3.size() != 0)
        cmp_res("l3", q3.pop_front(), {err_flags3, err_cycle3, err_bank3, read_count3, pass3});
    end
  end

  function automatic res_t mk(input int flags, input int cyc, input int bank, input int rc, input int ps);
    return {8'(flags), CW'(cyc), 4'(bank), (IW+1)'(rc), 1'(ps)};
  endfunction

  task automatic clr();
    for (int i = 0; i < 128; i++) tbl[i] = '0;
  endtask

  task automatic ent(input int c, input logic [2:0] op, input int bank, input int row, input int id);
    tbl[c] = {op, 4'(bank), RW'(row), IW'(id)};
  endtask

  task automatic table_a();
    clr();
    ent(0, CMD_ACT, 0, 'h200, 0);
    ent(14, CMD_RD, 0, 0, 0);
    ent(18, CMD_RD, 0, 0, 1);
    ent(22, CMD_RD, 0, 0, 2);
  endtask

  task automatic wait_dones(input int b1, input int b3);
    int k;
    for (k = 0; k < 500; k++) begin
      @(posedge clk); #2;
      if (done_cnt1 > b1 && done_cnt3 > b3) break;
    end
    chk("done within budget", 32'(k < 500), 32'd1);
  endtask

  task automatic run(input int maxc, input int expr, input res_t e);
    int b1, b3;
    b1 = done_cnt1; b3 = done_cnt3;
    q1.push_back(e); q3.push_back(e);
    @(negedge clk);
    max_cycle = CW'(maxc); expected_reads = IW'(expr); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_dones(b1, b3);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_idle(input string who, input logic en, input logic [CW-1:0] rc,
                            input logic bz, input logic dn, input logic ps, input logic [7:0] fl,
                            input logic [CW-1:0] ec, input logic [3:0] eb, input logic [IW:0] cnt);
    chk({who, " rd_en"}, 32'(en), 32'd0);
    chk({who, " rd_cycle"}, 32'(rc), 32'd0);
    chk({who, " busy"}, 32'(bz), 32'd0);
    chk({who, " done"}, 32'(dn), 32'd0);
    chk({who, " pass"}, 32'(ps), 32'd0);
    chk({who, " err_flags"}, 32'(fl), 32'd0);
    chk({who, " err_cycle"}, 32'(ec), 32'd0);
    chk({who, " err_bank"}, 32'(eb), 32'd0);
    chk({who, " read_count"}, 32'(cnt), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b1, b3, n1, n3, last1, last3, dc1, dc3, nd1, nd3, bad1, bad3;
    clr();
    repeat (3) @(negedge clk);
    check_idle("rst l1", rd_en1, rd_cycle1, busy1, done1, pass1, err_flags1, err_cycle1, err_bank1, read_count1);
    check_idle("rst l3", rd_en3, rd_cycle3, busy3, done3, pass3, err_flags3, err_cycle3, err_bank3, read_count3);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean three-read table
    table_a();
    run(22, 3, mk(0, 0, 0, 3, 1));

    // ACT / PRE / ACT / RD with legal spacing, then tRP short by one
    clr();
    ent(0, CMD_ACT, 0, 1, 0);
    ent(32, CMD_PRE, 0, 0, 0);
    ent(46, CMD_ACT, 0, 11, 0);
    ent(60, CMD_RD, 0, 0, 0);
    run(60, 1, mk(0, 0, 0, 1, 1));
    tbl[46] = '0;
    ent(45, CMD_ACT, 0, 11, 0);
    run(60, 1, mk('h08, 45, 0, 1, 0));

    // RD to closed bank 5, then double ACT; first error capture holds
    clr();
    ent(3, CMD_RD, 5, 0, 0);
    ent(10, CMD_ACT, 5, 7, 0);
    ent(20, CMD_ACT, 5, 8, 0);
    run(20, 1, mk('h03, 3, 5, 1, 0));

    // tRCD and tRAS both short on bank 2
    clr();
    ent(0, CMD_ACT, 2, 3, 0);
    ent(13, CMD_RD, 2, 0, 5);
    ent(31, CMD_PRE, 2, 0, 0);
    run(31, 1, mk('h14, 13, 2, 1, 0));

    // Duplicate ID plus short count
    clr();
    ent(0, CMD_ACT, 0, 'h200, 0);
    ent(14, CMD_RD, 0, 0, 0);
    ent(18, CMD_RD, 0, 0, 2);
    ent(22, CMD_RD, 0, 0, 2);
    run(22, 4, mk('hA0, 22, 0, 3, 0));

    // Count mismatch only: error reported at the last scanned index
    table_a();
    run(22, 4, mk('h80, 32, 0, 3, 0));

    // Unknown opcode on bank 3, then out-of-range request ID
    clr();
    ent(7, 3'd5, 3, 0, 0);
    ent(0, CMD_ACT, 1, 4, 0);
    ent(14, CMD_RD, 1, 0, 64);
    run(14, 1, mk('h60, 7, 3, 1, 0));

    // max_cycle=0: scan length and done latency for both read latencies
    clr();
    b1 = done_cnt1; b3 = done_cnt3;
    q1.push_back(mk(0, 0, 0, 0, 1)); q3.push_back(mk(0, 0, 0, 0, 1));
    n1 = 0; n3 = 0; last1 = -1; last3 = -1; dc1 = -100; dc3 = -100;
    nd1 = 0; nd3 = 0; bad1 = 0; bad3 = 0;
    @(negedge clk);
    max_cycle = '0; expected_reads = '0; start = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (rd_en1) begin if (rd_cycle1 !== CW'(n1)) bad1++; n1++; last1 = cyc; end
      if (rd_en3) begin if (rd_cycle3 !== CW'(n3)) bad3++; n3++; last3 = cyc; end
      if (done1) begin nd1++; dc1 = cyc; end
      if (done3) begin nd3++; dc3 = cyc; end
    end
    chk("l1 scan length", 32'(n1), 32'd11);
    chk("l3 scan length", 32'(n3), 32'd11);
    chk("l1 rd_cycle sequence", 32'(bad1), 32'd0);
    chk("l3 rd_cycle sequence", 32'(bad3), 32'd0);
    chk("l1 done latency", 32'(dc1 - last1), 32'd3);
    chk("l3 done latency", 32'(dc3 - last3), 32'd5);
    chk("l1 done pulse width", 32'(nd1), 32'd1);
    chk("l3 done pulse width", 32'(nd3), 32'd1);

    // Reset in the middle of a scan
    table_a();
    b1 = done_cnt1; b3 = done_cnt3;
    @(negedge clk);
    max_cycle = CW'(22); expected_reads = IW'(3); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle("midrst l1", rd_en1, rd_cycle1, busy1, done1, pass1, err_flags1, err_cycle1, err_bank1, read_count1);
    check_idle("midrst l3", rd_en3, rd_cycle3, busy3, done3, pass3, err_flags3, err_cycle3, err_bank3, read_count3);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("l1 no done after reset", 32'(done_cnt1 - b1), 32'd0);
    chk("l3 no done after reset", 32'(done_cnt3 - b3), 32'd0);

    // start while busy must not restart the scan
    b1 = done_cnt1; b3 = done_cnt3;
    q1.push_back(mk(0, 0, 0, 3, 1)); q3.push_back(mk(0, 0, 0, 3, 1));
    @(negedge clk);
    max_cycle = CW'(22); expected_reads = IW'(3); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("l1 rd_cycle after busy start", 32'(rd_cycle1), 32'd5);
    chk("l3 rd_cycle after busy start", 32'(rd_cycle3), 32'd5);
    wait_dones(b1, b3);
    repeat (30) @(negedge clk);
    chk("l1 single done", 32'(done_cnt1 - b1), 32'd1);
    chk("l3 single done", 32'(done_cnt3 - b3), 32'd1);
    chk("l1 sb drained", 32'(q1.size()), 32'd0);
    chk("l3 sb drained", 32'(q3.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
